// File: rtl/clock_divider_prog_pkg.sv
// rtl/clock_divider_prog_pkg.sv - shared constants for the programmable clock divider
package clock_divider_prog_pkg;

  // clock_out selection
  localparam logic MODE_PULSE  = 1'b0;
  localparam logic MODE_SQUARE = 1'b1;

  // Defaults for top-level divider instances
  localparam int DEF_WIDTH = 18;
  localparam int DEF_DIV   = 200000;

endpackage

// File: rtl/clock_divider_prog_if.sv
// rtl/clock_divider_prog_if.sv - control/status bundle of the programmable clock divider
interface clock_divider_prog_if
  import clock_divider_prog_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             enable;
  logic             sync_clear;
  logic             mode;
  logic             load_div;
  logic [WIDTH-1:0] div_value;
  logic             tick;
  logic             clock_out;
  logic [WIDTH-1:0] count;
  logic             pending;

  modport master (
    output enable, sync_clear, mode, load_div, div_value,
    input  tick, clock_out, count, pending
  );

  modport slave (
    input  enable, sync_clear, mode, load_div, div_value,
    output tick, clock_out, count, pending
  );

endinterface

// File: rtl/clock_divider_prog_up_counter_n.sv
// rtl/clock_divider_prog_up_counter_n.sv - enabled up-counter wrapping at a runtime terminal value
module up_counter_n #(
  parameter int WIDTH = 18
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_terminal,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;

  // Wrap flags the enabled edge on which the counter returns to zero
  assign o_wrap  = i_enable && (r_count == i_terminal);
  assign o_count = r_count;

  // Count register: clear beats enable, wrap restarts the period
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - programmable clock-enable generator with glitch-free divisor reload
module clock_divider_prog
  import clock_divider_prog_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input logic                 i_clock,
  input logic                 i_reset,
  clock_divider_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_div_pend;
  logic             r_pending;
  logic             r_tick;
  logic             r_clock_out;

  logic [WIDTH-1:0] w_n;
  logic [WIDTH-1:0] w_terminal;
  logic [WIDTH-1:0] w_count;
  logic             w_wrap;
  logic             w_boundary;
  logic [WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0] w_n_next;
  logic [WIDTH-1:0] w_half_next;
  logic [WIDTH-1:0] w_count_next;

  // A zero divisor behaves as divide-by-one; N >= 1 so N-1 never underflows
  assign w_n        = (r_div == '0) ? WIDTH'(1) : r_div;
  assign w_terminal = w_n - 1'b1;

  up_counter_n #(
    .WIDTH(WIDTH)
  ) u_counter (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_enable  (bus.enable),
    .i_clear   (bus.sync_clear),
    .i_terminal(w_terminal),
    .o_count   (w_count),
    .o_wrap    (w_wrap)
  );

  // Divisor changes only at a period boundary; a same-cycle load beats the pending value
  always_comb begin
    w_boundary = bus.sync_clear | w_wrap;
    w_div_next = r_div;
    if (w_boundary) begin
      if (bus.load_div) begin
        w_div_next = bus.div_value;
      end else if (r_pending) begin
        w_div_next = r_div_pend;
      end
    end
    w_n_next    = (w_div_next == '0) ? WIDTH'(1) : w_div_next;
    w_half_next = w_n_next >> 1;
    if (bus.sync_clear || w_wrap) begin
      w_count_next = '0;
    end else if (bus.enable) begin
      w_count_next = w_count + 1'b1;
    end else begin
      w_count_next = w_count;
    end
  end

  // Divisor shadow register: apply at boundary, otherwise stage loads as pending
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_div      <= DIV_RESET;
      r_div_pend <= DIV_RESET;
      r_pending  <= 1'b0;
    end else if (w_boundary) begin
      r_div     <= w_div_next;
      r_pending <= 1'b0;
    end else if (bus.load_div) begin
      r_div_pend <= bus.div_value;
      r_pending  <= 1'b1;
    end
  end

  // Tick and divided output; square mode holds its level while the counter is frozen
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_tick      <= 1'b0;
      r_clock_out <= 1'b0;
    end else if (bus.sync_clear) begin
      r_tick      <= 1'b0;
      r_clock_out <= 1'b0;
    end else begin
      r_tick <= w_wrap;
      if (bus.mode == MODE_PULSE) begin
        r_clock_out <= w_wrap;
      end else if (bus.enable) begin
        r_clock_out <= (w_count_next >= w_half_next);
      end
    end
  end

  assign bus.tick      = r_tick;
  assign bus.clock_out = r_clock_out;
  assign bus.count     = w_count;
  assign bus.pending   = r_pending;

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - self-checking bench for clock_divider_prog
module tb_clock_divider_prog;

  localparam int W    = 8;
  localparam int DDIV = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  clock_divider_prog_if #(.WIDTH(W)) bus ();

  clock_divider_prog #(
    .WIDTH      (W),
    .DEFAULT_DIV(DDIV)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: period position advances modulo the effective divisor
  int m_count, m_div, m_pval;
  bit m_pend, m_tick, m_cout;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int n, nc;
    bit bnd;
    if (!rst_n) begin
      m_count = 0; m_div = DDIV; m_pval = DDIV;
      m_pend = 0; m_tick = 0; m_cout = 0;
    end else begin
      n = eff(m_div);
      if (bus.sync_clear) begin
        nc = 0; bnd = 1; m_tick = 0;
      end else if (bus.enable) begin
        nc = (m_count + 1) % n; bnd = (nc == 0); m_tick = bnd;
      end else begin
        nc = m_count; bnd = 0; m_tick = 0;
      end
      if (bnd) begin
        if (bus.load_div) m_div = int'(bus.div_value);
        else if (m_pend) m_div = m_pval;
        m_pend = 0;
      end else if (bus.load_div) begin
        m_pval = int'(bus.div_value);
        m_pend = 1;
      end
      if (bus.sync_clear) m_cout = 0;
      else if (!bus.mode) m_cout = m_tick;
      else if (bus.enable) m_cout = (nc >= eff(m_div) / 2);
      m_count = nc;
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    check("model_count", int'(bus.count), m_count);
    check("model_tick", int'(bus.tick), int'(m_tick));
    check("model_clock_out", int'(bus.clock_out), int'(m_cout));
    check("model_pending", int'(bus.pending), int'(m_pend));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycles up to and including the next tick, and how many of them had clock_out low
  task automatic measure(output int n, output int lows);
    n = 0;
    lows = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.clock_out) lows++;
    end while (!bus.tick && n < 40);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, lows;
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    bus.enable = 1'b1;
    bus.sync_clear = 1'b0;
    bus.mode = 1'b0;
    bus.load_div = 1'b0;
    bus.div_value = '0;
    #1 rst_n = 1'b0;
    step(2);
    check("rst_count", int'(bus.count), 0);
    check("rst_tick", int'(bus.tick), 0);
    check("rst_pending", int'(bus.pending), 0);
    rst_n = 1'b1;

    // Pulse mode, N=5
    step(4);
    check("t1_count4", int'(bus.count), 4);
    check("t1_no_tick", int'(bus.tick), 0);
    step(1);
    check("t1_tick5", int'(bus.tick), 1);
    check("t1_cout5", int'(bus.clock_out), 1);
    check("t1_count0", int'(bus.count), 0);
    step(5);
    check("t1_tick10", int'(bus.tick), 1);

    // Square mode N=5, then reload 6
    bus.mode = 1'b1;
    measure(n, lows);
    check("t2_period5", n, 5);
    check("t2_low5", lows, 2);
    bus.load_div = 1'b1;
    bus.div_value = 8'd6;
    step(1);
    bus.load_div = 1'b0;
    check("t2_pending", int'(bus.pending), 1);
    measure(n, lows);
    check("t2_rest4", n, 4);
    check("t2_rest_low", lows, 1);
    check("t2_pend_clr", int'(bus.pending), 0);
    measure(n, lows);
    check("t2_period6", n, 6);
    check("t2_low6", lows, 3);

    // Pending reload, last load wins
    bus.mode = 1'b0;
    step(2);
    check("t3_count2", int'(bus.count), 2);
    bus.load_div = 1'b1;
    bus.div_value = 8'd9;
    step(1);
    check("t3_pending", int'(bus.pending), 1);
    bus.div_value = 8'd7;
    step(1);
    bus.load_div = 1'b0;
    measure(n, lows);
    check("t3_wrap_old", n, 2);
    check("t3_pulse_cout", int'(bus.clock_out), 1);
    measure(n, lows);
    check("t3_period7", n, 7);

    // Enable low freezes the period
    step(3);
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("t4_hold_count", int'(bus.count), 3);
      check("t4_hold_tick", int'(bus.tick), 0);
    end
    bus.enable = 1'b1;
    measure(n, lows);
    check("t4_resume", n, 4);

    // Clear with same-cycle load, then divisor 0
    step(3);
    bus.sync_clear = 1'b1;
    bus.load_div = 1'b1;
    bus.div_value = 8'd4;
    step(1);
    check("t5_clr_count", int'(bus.count), 0);
    check("t5_clr_cout", int'(bus.clock_out), 0);
    check("t5_clr_pend", int'(bus.pending), 0);
    bus.sync_clear = 1'b0;
    bus.load_div = 1'b0;
    measure(n, lows);
    check("t5_period4", n, 4);
    bus.sync_clear = 1'b1;
    bus.load_div = 1'b1;
    bus.div_value = 8'd0;
    step(1);
    bus.sync_clear = 1'b0;
    bus.load_div = 1'b0;
    step(1);
    check("t5_n1_tick_a", int'(bus.tick), 1);
    step(1);
    check("t5_n1_tick_b", int'(bus.tick), 1);
    bus.mode = 1'b1;
    step(1);
    check("t5_n1_sq_cout", int'(bus.clock_out), 1);
    check("t5_n1_sq_tick", int'(bus.tick), 1);

    // Asynchronous reset mid-period with a pending divisor
    bus.sync_clear = 1'b1;
    bus.load_div = 1'b1;
    bus.div_value = 8'd10;
    step(1);
    bus.sync_clear = 1'b0;
    bus.div_value = 8'd3;
    step(1);
    bus.load_div = 1'b0;
    check("t6_pending", int'(bus.pending), 1);
    step(2);
    check("t6_count3", int'(bus.count), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_count", int'(bus.count), 0);
    check("t6_async_tick", int'(bus.tick), 0);
    check("t6_async_cout", int'(bus.clock_out), 0);
    check("t6_async_pend", int'(bus.pending), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mode = 1'b0;
    measure(n, lows);
    check("t6_default_a", n, 5);
    measure(n, lows);
    check("t6_default_b", n, 5);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
